// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; results are 2*WIDTH bits wide.
// Optional iterative shift-add multiply is built when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               zero,
  output logic               err,
  output logic               busy
);

  localparam int RW = 2 * WIDTH;
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  function automatic logic [RW-1:0] alu_fn(input logic [2:0] fop,
                                           input logic [WIDTH-1:0] fa,
                                           input logic [WIDTH-1:0] fb);
    logic [RW-1:0] ea, eb;
    ea = {{WIDTH{1'b0}}, fa};
    eb = {{WIDTH{1'b0}}, fb};
    case (op_e'(fop))
      OP_ADD:  alu_fn = ea + eb;
      OP_SUB:  alu_fn = ea - eb;
      OP_NOT:  alu_fn = ~ea;
      OP_AND:  alu_fn = ea & eb;
      OP_OR:   alu_fn = ea | eb;
      OP_XOR:  alu_fn = ea ^ eb;
      OP_SHL:  alu_fn = ea << fb[SW-1:0];
      default: alu_fn = '0;
    endcase
  endfunction

  logic          ov_q, ov_d;
  logic [RW-1:0] y_q, y_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;

  logic          load;
  logic [RW-1:0] res;
  logic          res_err;
  logic          accept;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    pp;

  assign in_ready = (state_q == S_IDLE) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == S_MUL);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    res      = '0;
    res_err  = 1'b0;
    pp       = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            load = 1'b1;
            res  = alu_fn(op, a, b);
          end
        end
      end
      S_MUL: begin
        // One partial product per clock, selected by multiplicand bit cnt
        if (mcand_q[cnt_q])
          pp = {{WIDTH{1'b0}}, mplier_q} << cnt_q;
        acc_d = acc_q + pp;
        cnt_d = cnt_q + SW'(1);
        if (cnt_q == CNT_LAST) begin
          load    = 1'b1;
          res     = acc_q + pp;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign in_ready = !ov_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = 1'b0;

  // Without the multiplier, op 111 completes immediately and is flagged.
  always_comb begin
    load    = accept;
    res     = '0;
    res_err = 1'b0;
    if (accept) begin
      if (op == OP_MUL) res_err = 1'b1;
      else              res     = alu_fn(op, a, b);
    end
  end
`endif

  always_comb begin
    ov_d   = ov_q;
    y_d    = y_q;
    zero_d = zero_q;
    err_d  = err_q;
    if (ov_q && out_ready) ov_d = 1'b0;
    if (load) begin
      ov_d   = 1'b1;
      y_d    = res;
      zero_d = (res == '0);
      err_d  = res_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q   <= 1'b0;
      y_q    <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ov_q   <= ov_d;
      y_q    <= y_d;
      zero_q <= zero_d;
      err_q  <= err_d;
    end
  end

  assign out_valid = ov_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=4): directed literal checks plus a random run against
// a cycle-count reference model; follows ALU_SEQ_MUL_EN if it is defined.
module tb_alu_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [2*W-1:0] y;
  logic         zero, err, busy;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic, truncated to 2*W bits.
  function automatic int ref_y(input int fop, input int fa, input int fb);
    int r;
    case (fop)
      0: r = fa + fb;
      1: r = fa - fb;
      2: r = ~fa;
      3: r = fa & fb;
      4: r = fa | fb;
      5: r = fa ^ fb;
      6: r = fa << (fb % W);
      default: r = MUL_EN ? fa * fb : 0;
    endcase
    return r & ((1 << (2*W)) - 1);
  endfunction

  // Abstract model: output slot plus a countdown of multiply cycles remaining.
  bit m_ov;
  int m_y;
  bit m_zero, m_err;
  int m_busy, m_mres;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ov = 0; m_y = 0; m_zero = 0; m_err = 0; m_busy = 0; m_mres = 0;
    end else begin
      bit rdy, fire;
      rdy  = (m_busy == 0) && (!m_ov || out_ready);
      fire = in_valid && rdy;
      if (m_ov && out_ready) m_ov = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_ov = 1; m_y = m_mres; m_zero = (m_mres == 0); m_err = 0;
        end
      end
      if (fire) begin
        if (op == 3'd7 && MUL_EN) begin
          m_busy = W;
          m_mres = ref_y(7, int'(a), int'(b));
        end else begin
          m_ov = 1;
          m_y = ref_y(int'(op), int'(a), int'(b));
          m_zero = (m_y == 0);
          m_err = (op == 3'd7);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cmp_out_valid", 32'(out_valid), 32'(m_ov));
      chk("cmp_in_ready", 32'(in_ready), 32'((m_busy == 0) && (!m_ov || out_ready)));
      chk("cmp_busy", 32'(busy), 32'(m_busy > 0));
      chk("cmp_y", 32'(y), 32'(m_y));
      chk("cmp_zero", 32'(zero), 32'(m_zero));
      chk("cmp_err", 32'(err), 32'(m_err));
    end
  end

  // Present an op and hold it until accepted; returns 1 ns after the accept edge.
  task automatic send(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
    bit done = 0;
    in_valid = 1; op = o; a = xa; b = xb;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1; rst = 0; cmp_en = 1;

    // Basic single-cycle results
    send(3'd0, 4'd9, 4'd8);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_y", 32'(y), 32'h11);
    chk("add_zero", 32'(zero), 0);
    send(3'd1, 4'd3, 4'd5);
    chk("sub_y", 32'(y), 32'hFE);
    send(3'd2, 4'h5, 4'h0);
    chk("not_y", 32'(y), 32'hFA);
    send(3'd3, 4'hC, 4'h3);
    chk("and_y", 32'(y), 32'h00);
    chk("and_zero", 32'(zero), 1);

    // Back-to-back stream, one result per cycle in order
    in_valid = 1; op = 3'd0; a = 4'd7; b = 4'd6;
    @(posedge clk); #1; chk("s0_y", 32'(y), 32'h0D);
    op = 3'd1; a = 4'd2; b = 4'd3;
    @(posedge clk); #1; chk("s1_y", 32'(y), 32'hFF);
    op = 3'd5; a = 4'hA; b = 4'h5;
    @(posedge clk); #1; chk("s2_y", 32'(y), 32'h0F);
    op = 3'd6; a = 4'd3; b = 4'd6;
    @(posedge clk); #1; chk("s3_y", 32'(y), 32'h0C);
    chk("s3_valid", 32'(out_valid), 1);
    // Stall: result must hold and nothing new accepted
    out_ready = 0; op = 3'd0; a = 4'd1; b = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_y", 32'(y), 32'h0C);
    end
    out_ready = 1;
    @(posedge clk); #1; in_valid = 0;
    chk("stall_release_y", 32'(y), 32'h02);

    if (MUL_EN) begin
      send(3'd7, 4'd15, 4'd15);
      for (int i = 0; i < W; i++) begin
        chk("mul_busy", 32'(busy), 1);
        chk("mul_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
      end
      chk("mul_valid", 32'(out_valid), 1);
      chk("mul_y", 32'(y), 32'hE1);
      chk("mul_err", 32'(err), 0);
      send(3'd7, 4'd0, 4'd7);
      for (int i = 0; i < W; i++) begin @(posedge clk); #1; end
      chk("mul0_y", 32'(y), 0);
      chk("mul0_zero", 32'(zero), 1);
      // Reset during the multiply
      send(3'd7, 4'd5, 4'd5);
      @(posedge clk); #1;
      rst = 1; #1;
      chk("rstmul_valid", 32'(out_valid), 0);
      chk("rstmul_busy", 32'(busy), 0);
    end else begin
      send(3'd7, 4'd3, 4'd3);
      chk("nomul_valid", 32'(out_valid), 1);
      chk("nomul_y", 32'(y), 0);
      chk("nomul_zero", 32'(zero), 1);
      chk("nomul_err", 32'(err), 1);
      send(3'd0, 4'd2, 4'd2);
      chk("nomul_next_err", 32'(err), 0);
      chk("nomul_next_y", 32'(y), 32'h04);
      rst = 1; #1;
      chk("rstmid_valid", 32'(out_valid), 0);
      chk("rstmid_y", 32'(y), 0);
    end
    @(posedge clk); #1; rst = 0;
    send(3'd0, 4'd1, 4'd1);
    chk("post_rst_y", 32'(y), 32'h02);

    // Random traffic checked each cycle by the compare process
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
